// File: rtl/apb4_sram_pkg.sv
// Shared types and sizing helpers for the APB4 scratch-SRAM controller.
package apb4_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte-offset bits inside one data word.
  function automatic int word_lsb_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Number of byte strobes per data word.
  function automatic int strb_w_f(input int data_w);
    return data_w / 8;
  endfunction

  // Counter width large enough for the longer of read latency and write waits.
  function automatic int cnt_w_f(input int rd_lat, input int wr_wait);
    int max_v;
    max_v = (rd_lat > wr_wait) ? rd_lat : wr_wait;
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/spram_be_generic.sv
// Generic single-port SRAM with per-byte write enables and a RD_LAT-deep read pipeline.
module spram_be_generic import apb4_sram_pkg::*; #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 1
) (
  input  logic                              clk,
  input  logic                              en,
  input  logic                              we,
  input  logic [strb_w_f(DATA_WIDTH)-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             din,
  output logic [DATA_WIDTH-1:0]             dout
);

  localparam int STRB_W = strb_w_f(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r  [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_r [RD_LAT];

  // Byte-masked write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (be[b]) begin
          mem_r[addr][b*8 +: 8] <= din[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 samples the array on a read, later stages delay it.
  always_ff @(posedge clk) begin
    if (en && !we) begin
      pipe_r[0] <= mem_r[addr];
    end
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_r[s] <= pipe_r[s-1];
    end
  end

  assign dout = pipe_r[RD_LAT-1];

endmodule

// File: rtl/apb4_sram_ctrl.sv
// APB4 slave in front of a byte-writable single-port SRAM, with configurable
// read latency, write wait states and pslverr on out-of-range word indices.
module apb4_sram_ctrl import apb4_sram_pkg::*; #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int RD_LAT    = 1,
  parameter int WR_WAIT   = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          psel,
  input  logic                          penable,
  input  logic [ADDR_W-1:0]             paddr,
  input  logic                          pwrite,
  input  logic [DATA_W-1:0]             pwdata,
  input  logic [strb_w_f(DATA_W)-1:0]   pstrb,
  output logic [DATA_W-1:0]             prdata,
  output logic                          pready,
  output logic                          pslverr
);

  localparam int WORD_LSB = word_lsb_f(DATA_W);
  localparam int STRB_W   = strb_w_f(DATA_W);
  localparam int WIDX_W   = ADDR_W - WORD_LSB;
  localparam int MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W    = cnt_w_f(RD_LAT, WR_WAIT);
  localparam logic [CNT_W-1:0] RD_DONE = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_DONE = CNT_W'(WR_WAIT);

  state_t              state_r;
  logic [MEM_AW-1:0]   widx_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   strb_r;
  logic                write_r;
  logic                err_r;
  logic                mem_en_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [WIDX_W-1:0]   widx_s;
  logic                err_s;
  logic                setup_s;
  logic [DATA_W-1:0]   dout_s;

  assign widx_s  = paddr[ADDR_W-1:WORD_LSB];
  assign err_s   = (32'(widx_s) >= 32'(MEM_WORDS));
  assign setup_s = psel & ~penable;

  // Byte-offset address bits carry no meaning for word accesses.
  generate
    if (WORD_LSB > 0) begin : g_lsb
      logic unused_lsb_s;
      assign unused_lsb_s = ^paddr[WORD_LSB-1:0];
    end
  endgenerate

  // Transfer sequencer: captures the setup phase, issues one SRAM op in the
  // first WAIT cycle, times the response and drives the registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      widx_r   <= '0;
      wdata_r  <= '0;
      strb_r   <= '0;
      write_r  <= 1'b0;
      err_r    <= 1'b0;
      mem_en_r <= 1'b0;
      cnt_r    <= '0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
    end else begin
      mem_en_r <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            widx_r   <= widx_s[MEM_AW-1:0];
            wdata_r  <= pwdata;
            strb_r   <= pstrb;
            write_r  <= pwrite;
            err_r    <= err_s;
            mem_en_r <= ~err_s;
            cnt_r    <= '0;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (!psel) begin
            // Abort: an issued write still lands, a pending read is dropped.
            state_r <= IDLE;
          end else if (err_r) begin
            state_r <= RESP;
            pready  <= 1'b1;
            pslverr <= 1'b1;
            if (!write_r) begin
              prdata <= '0;
            end
          end else if (write_r) begin
            if (cnt_r == WR_DONE) begin
              state_r <= RESP;
              pready  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end else begin
            if (cnt_r == RD_DONE) begin
              state_r <= RESP;
              pready  <= 1'b1;
              prdata  <= dout_s;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  spram_be_generic #(
    .ADDR_WIDTH (MEM_AW),
    .DATA_WIDTH (DATA_W),
    .DEPTH      (MEM_WORDS),
    .RD_LAT     (RD_LAT)
  ) u_ram (
    .clk  (clk),
    .en   (mem_en_r),
    .we   (write_r),
    .be   (strb_r),
    .addr (widx_r),
    .din  (wdata_r),
    .dout (dout_s)
  );

endmodule

// File: tb/tb_apb4_sram_ctrl.sv
// Self-checking bench for apb4_sram_ctrl: table of APB transfers with a
// scoreboard queue, plus hand-written abort and mid-transfer reset sequences.
module tb_apb4_sram_ctrl;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 512;
  localparam int RD_LAT    = 3;
  localparam int WR_WAIT   = 5;
  localparam int BUDGET    = 40;
  localparam int NVEC      = 20;

  logic              clk;
  logic              rstn;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [3:0]        pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd;
  logic [31:0] got_rd;
  logic        got_err;
  int          got_cyc;
  int          hits;

  apb4_sram_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS),
    .RD_LAT    (RD_LAT),
    .WR_WAIT   (WR_WAIT)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer; returns the response seen in the pready cycle and the
  // number of access-phase cycles including that cycle.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rd, output logic err,
                          output int cyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    while (pready !== 1'b1 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check("pready_single_cycle", {31'd0, pready}, 32'd0);
  endtask

  // Start a transfer and stop after n access cycles, leaving psel high.
  task automatic apb_start(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input int n);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 12'h000, 32'h01234567, 4'hF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 12'h010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 12'h020, 32'h00000000, 4'hF, 32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 12'h020, 32'h00000000, 4'hF, 32'h11BB33DD, 1'b0};
    vecs[8]  = '{1'b0, 12'h800, 32'h00000000, 4'hF, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 12'h800, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 12'h000, 32'h00000000, 4'hF, 32'h01234567, 1'b0};
    vecs[11] = '{1'b0, 12'hFFC, 32'h00000000, 4'hF, 32'h00000000, 1'b1};
    vecs[12] = '{1'b1, 12'h7FC, 32'h00000000, 4'hF, 32'h00000000, 1'b0};
    vecs[13] = '{1'b1, 12'h7FC, 32'h89ABCDEF, 4'h9, 32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 12'h7FC, 32'h00000000, 4'hF, 32'h890000EF, 1'b0};
    vecs[15] = '{1'b1, 12'h010, 32'h55667788, 4'hA, 32'h00000000, 1'b0};
    vecs[16] = '{1'b0, 12'h013, 32'h00000000, 4'hF, 32'h55AD77EF, 1'b0};
    vecs[17] = '{1'b0, 12'h020, 32'h00000000, 4'hF, 32'h11BB33DD, 1'b0};
    vecs[18] = '{1'b1, 12'h7FF, 32'h12345678, 4'hF, 32'h00000000, 1'b0};
    vecs[19] = '{1'b0, 12'h7FC, 32'h00000000, 4'hF, 32'h12345678, 1'b0};

    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_prdata",  prdata, 32'h0);
    check("reset_pready",  {31'd0, pready}, 32'd0);
    check("reset_pslverr", {31'd0, pslverr}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table: back-to-back transfers, expectations queued then compared.
    last_rd = 32'h0;
    for (int i = 0; i < NVEC; i++) begin
      e.idx = i;
      e.err = vecs[i].exp_err;
      e.rd  = vecs[i].wr ? last_rd : vecs[i].exp_rd;
      e.cyc = vecs[i].exp_err ? 2 : (vecs[i].wr ? WR_WAIT + 2 : RD_LAT + 2);
      if (!vecs[i].wr) last_rd = vecs[i].exp_rd;
      sb_q.push_back(e);
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, got_rd, got_err, got_cyc);
      e = sb_q.pop_front();
      check($sformatf("vec%0d_prdata", e.idx), got_rd, e.rd);
      check($sformatf("vec%0d_pslverr", e.idx), {31'd0, got_err}, {31'd0, e.err});
      check($sformatf("vec%0d_cycles", e.idx), got_cyc, e.cyc);
    end

    // Write aborted during its wait states: no pready, but the word is written.
    apb_start(1'b1, 12'h100, 32'h0BADCAFE, 3);
    psel = 1'b0; penable = 1'b0;
    hits = (pready === 1'b1) ? 1 : 0;
    repeat (WR_WAIT + 4) begin
      @(posedge clk); #1;
      if (pready === 1'b1) hits++;
    end
    check("abort_wr_no_pready", hits, 0);
    apb_xfer(1'b0, 12'h100, 32'h0, 4'hF, got_rd, got_err, got_cyc);
    check("abort_wr_readback", got_rd, 32'h0BADCAFE);
    check("abort_wr_next_cycles", got_cyc, RD_LAT + 2);

    // Read aborted mid-latency: no pready, prdata keeps the previous read.
    apb_xfer(1'b0, 12'h020, 32'h0, 4'hF, got_rd, got_err, got_cyc);
    check("pre_abort_rd", got_rd, 32'h11BB33DD);
    apb_start(1'b0, 12'h100, 32'h0, 2);
    psel = 1'b0; penable = 1'b0;
    hits = (pready === 1'b1) ? 1 : 0;
    repeat (RD_LAT + 4) begin
      @(posedge clk); #1;
      if (pready === 1'b1) hits++;
    end
    check("abort_rd_no_pready", hits, 0);
    check("abort_rd_prdata_kept", prdata, 32'h11BB33DD);

    // Reset asserted in the WAIT state of a read.
    apb_start(1'b0, 12'h100, 32'h0, 2);
    rstn = 1'b0;
    #1;
    check("midrst_prdata",  prdata, 32'h0);
    check("midrst_pready",  {31'd0, pready}, 32'd0);
    check("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b1, 12'h040, 32'hCAFEBABE, 4'hF, got_rd, got_err, got_cyc);
    check("postrst_wr_cycles", got_cyc, WR_WAIT + 2);
    check("postrst_wr_pslverr", {31'd0, got_err}, 32'd0);
    apb_xfer(1'b0, 12'h040, 32'h0, 4'hF, got_rd, got_err, got_cyc);
    check("postrst_rd_data", got_rd, 32'hCAFEBABE);
    check("postrst_rd_cycles", got_cyc, RD_LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb4_sram_ctrl.md
Name: apb4_sram_ctrl

Overview:
APB4 slave fronting a parametrised single-port SRAM. Adds byte-strobe writes (pstrb), a parametrised SRAM read latency, and programmable write wait states. Out-of-range accesses are flagged via pslverr. Sits on the peripheral APB fabric as a general-purpose scratch memory.

Parameters:
ADDR_W, 12, byte-address width of paddr
DATA_W, 32, data width; must be 8/16/32/64
MEM_WORDS, 1024, implemented depth in words; must be ≤ 2^(ADDR_W-WORD_LSB)
RD_LAT, 1, SRAM read latency in cycles (1..3)
WR_WAIT, 0, extra wait states inserted on writes (0..7)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
psel  in  1  APB select
penable  in  1  APB access phase
paddr  in  ADDR_W  byte address; low WORD_LSB bits ignored
pwrite  in  1  1=write, 0=read
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  byte write strobes; ignored on reads
prdata  out  DATA_W  read data, registered
pready  out  1  transfer complete
pslverr  out  1  error response, valid only when pready=1

Behaviour:
- Reset (async): state=IDLE, prdata=0, pready=0, pslverr=0, wait counter=0. SRAM contents unchanged or undefined.
- Word index: widx = paddr[ADDR_W-1:WORD_LSB]. err = (widx ≥ MEM_WORDS).
- FSM states: IDLE, WAIT, RESP.
- IDLE: on psel & !penable (setup), register widx, pwdata, pstrb, pwrite, err, then go to WAIT. Otherwise stay.
- WAIT, first cycle:
  - If err: no SRAM access; go to RESP next edge.
  - If write: SRAM cs=1, we=1, byte-enable=pstrb_q, for exactly one cycle. Count WR_WAIT further cycles, then go to RESP.
  - If read: SRAM cs=1, we=0, for one cycle. At cycle RD_LAT after the issue cycle, register dout into prdata, then go to RESP.
- RESP: pready=1 and pslverr=err_q, both for exactly one cycle. Next state is IDLE, or WAIT if back-to-back setup is present (not legal APB, since penable is high in RESP; the FSM simply returns to IDLE).
- pready and pslverr are registered outputs. pready=0 in IDLE and WAIT.
- Access-phase length, counting cycles with penable=1, incl. the pready cycle:
  - write: WR_WAIT+2
  - read: RD_LAT+2
  - error: 2
- prdata:
  - Holds the last successful read value.
  - On an errored read it is forced to 0 in RESP.
  - Unchanged on writes.
- Errored write: SRAM not touched.
- Write with pstrb=0: cs asserted with all byte enables low; memory unchanged; pslverr=0.
- psel deasserted while in WAIT or RESP (protocol abort): FSM goes to IDLE next edge. A write already issued completes; an in-flight read is discarded and prdata keeps its old value. No pready pulse is produced.
- Only one SRAM op per transfer. No address or data change is sampled after setup.

Decomposition:
- Package apb4_sram_pkg: state encoding (IDLE/WAIT/RESP), function for WORD_LSB = log2(DATA_W/8), STRB_W = DATA_W/8, counter width = clog2(max(RD_LAT,WR_WAIT)+1).
- Sub-module spram_be_generic:
  - Parameters ADDR_WIDTH, DATA_WIDTH, DEPTH, RD_LAT.
  - Ports: clk, en, we, be[STRB_W], addr, din, dout.
  - Per-byte write enable; dout pipelined by RD_LAT registers.
- Controller FSM and counter live in apb4_sram_ctrl.

Test Plan:
- Reset mid-read (RD_LAT=3, rstn low in WAIT) -> pready=0, pslverr=0, prdata=0 immediately; next transfer completes normally.
- Write 0xDEADBEEF to 0x010, pstrb=4'hF, then read 0x010 (defaults) -> write pready on 2nd access cycle; read prdata=0xDEADBEEF on 3rd; pslverr=0 on both.
- Byte strobes: preload 0x11223344 at 0x020; write 0xAABBCCDD with pstrb=4'b0101; read back -> 0x11BB33DD. Write with pstrb=0 -> 0x11BB33DD unchanged.
- Out of range: MEM_WORDS=512, ADDR_W=12, access paddr=0x800 -> pready and pslverr=1 on 2nd access cycle. Read returns prdata=0; a following read of 0x000 shows memory unmodified.
- Latency sweep: RD_LAT∈{1,2,3}, WR_WAIT∈{0,3,7} -> read pready at cycle RD_LAT+2, write pready at cycle WR_WAIT+2; back-to-back transfers have no lost data.
- Abort: drop psel during WAIT of a write with WR_WAIT=5 -> no pready pulse; FSM returns to IDLE; the written word is still updated on readback.
